// File: rtl/comm_pkg.sv
// Shared definitions for the host-side UART command master: baud default,
// master sequencing states and the command/response encoding.
package comm_pkg;

  localparam int BAUD_DIV_DEF = 109;
  localparam int BAUD_CNT_W   = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } master_state_t;

  // Command word: [15:14] opcode, [13:8] register address, [7:0] data
  localparam logic [1:0] CMD_OP_READ  = 2'b00;
  localparam logic [1:0] CMD_OP_WRITE = 2'b01;
  localparam logic [7:0] RESP_ACK     = 8'hA5;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] addr;
    logic [7:0] data;
  } cmd_word_t;

  function automatic logic [15:0] make_cmd(input logic [1:0] op,
                                           input logic [5:0] addr,
                                           input logic [7:0] data);
    cmd_word_t w;
    w.op   = op;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/uart_xcvr.sv
// 8N1 UART transmitter and receiver sharing one baud divisor; the two paths
// are completely independent apart from clock and reset.
module uart_xcvr
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_last,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] resp,
  output logic       resp_cmplt
);

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST      = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BAUD_CNT_W-1:0] BAUD_HALF_LAST = BAUD_CNT_W'(BAUD_DIV / 2 - 1);

  // ---------------- transmitter ----------------
  logic [BAUD_CNT_W-1:0] tx_baud_reg;
  logic [3:0]            tx_bit_reg;
  logic [8:0]            tx_shift_reg;
  logic                  tx_busy_reg;
  logic                  tx_line_reg;

  // Final clock of the stop bit; a new start may be accepted in this same
  // cycle so consecutive frames run back-to-back.
  assign tx_last = tx_busy_reg && (tx_baud_reg == BAUD_LAST) && (tx_bit_reg == 4'd9);
  assign TX      = tx_line_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '1;
      tx_busy_reg  <= 1'b0;
      tx_line_reg  <= 1'b1;
    end else if (tx_start && (!tx_busy_reg || tx_last)) begin
      tx_shift_reg <= {1'b1, tx_data};
      tx_line_reg  <= 1'b0;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_busy_reg  <= 1'b1;
    end else if (tx_busy_reg) begin
      if (tx_baud_reg == BAUD_LAST) begin
        tx_baud_reg <= '0;
        if (tx_bit_reg == 4'd9) begin
          tx_busy_reg <= 1'b0;
        end else begin
          tx_line_reg  <= tx_shift_reg[0];
          tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
          tx_bit_reg   <= tx_bit_reg + 4'd1;
        end
      end else begin
        tx_baud_reg <= tx_baud_reg + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]            rx_sync_reg;
  logic                  rx_prev_reg;
  logic                  rx_busy_reg;
  logic [BAUD_CNT_W-1:0] rx_baud_reg;
  logic [3:0]            rx_bit_reg;
  logic [7:0]            rx_shift_reg;
  logic [7:0]            resp_reg;
  logic                  resp_cmplt_reg;
  logic                  rx_s;
  logic                  rx_start_ok;
  logic                  rx_done;

  assign rx_s = rx_sync_reg[1];

  // bit slot 0 is the start bit, 1..8 data, 9 the stop bit
  assign rx_start_ok = rx_busy_reg && (rx_bit_reg == 4'd0) &&
                       (rx_baud_reg == BAUD_HALF_LAST) && !rx_s;
  assign rx_done     = rx_busy_reg && (rx_bit_reg == 4'd9) && (rx_baud_reg == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_reg <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], RX};
      rx_prev_reg <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy_reg  <= 1'b0;
      rx_baud_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else if (!rx_busy_reg) begin
      if (rx_prev_reg && !rx_s) begin
        rx_busy_reg <= 1'b1;
        rx_baud_reg <= '0;
        rx_bit_reg  <= '0;
      end
    end else if (rx_bit_reg == 4'd0) begin
      if (rx_baud_reg == BAUD_HALF_LAST) begin
        // start bit high at its centre: treat the edge as a glitch
        if (rx_s) begin
          rx_busy_reg <= 1'b0;
        end else begin
          rx_baud_reg <= '0;
          rx_bit_reg  <= 4'd1;
        end
      end else begin
        rx_baud_reg <= rx_baud_reg + 1'b1;
      end
    end else if (rx_baud_reg == BAUD_LAST) begin
      rx_baud_reg <= '0;
      if (rx_bit_reg == 4'd9) begin
        rx_busy_reg <= 1'b0;
      end else begin
        rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
        rx_bit_reg   <= rx_bit_reg + 4'd1;
      end
    end else begin
      rx_baud_reg <= rx_baud_reg + 1'b1;
    end
  end

  // Completion takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_reg       <= 8'h00;
      resp_cmplt_reg <= 1'b0;
    end else if (rx_done) begin
      resp_reg       <= rx_shift_reg;
      resp_cmplt_reg <= 1'b1;
    end else if (clr_rdy || rx_start_ok) begin
      resp_cmplt_reg <= 1'b0;
    end
  end

  assign resp       = resp_reg;
  assign resp_cmplt = resp_cmplt_reg;

endmodule

// File: rtl/comm_master.sv
// Host command master: latches a 16-bit command and sends it as two UART
// bytes (high first), flagging completion; responses come from uart_xcvr.
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_cmplt,
  output logic [7:0]  resp,
  output logic        resp_cmplt,
  input  logic        clr_rdy
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_SEND_HI = SEND_HI;
  localparam logic [1:0] ST_SEND_LO = SEND_LO;

  logic [1:0]  state_reg, state_next;
  logic [15:0] hold_reg, hold_next;
  logic        launch_reg, launch_next;
  logic        cmd_cmplt_reg, cmd_cmplt_next;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_last;

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    launch_next    = 1'b0;
    cmd_cmplt_next = cmd_cmplt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (snd_cmd) begin
          hold_next      = cmd;
          launch_next    = 1'b1;
          cmd_cmplt_next = 1'b0;
          state_next     = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (tx_last) state_next = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (tx_last) begin
          cmd_cmplt_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      hold_reg      <= 16'h0000;
      launch_reg    <= 1'b0;
      cmd_cmplt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      launch_reg    <= launch_next;
      cmd_cmplt_reg <= cmd_cmplt_next;
    end
  end

  // High byte launches from the freshly loaded holding register; the low
  // byte is chained onto the last stop-bit clock of the high byte.
  assign tx_start = launch_reg || ((state_reg == ST_SEND_HI) && tx_last);
  assign tx_data  = launch_reg ? hold_reg[15:8] : hold_reg[7:0];

  assign cmd_cmplt = cmd_cmplt_reg;

  uart_xcvr #(
    .BAUD_DIV(BAUD_DIV)
  ) u_xcvr (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .TX         (TX),
    .RX         (RX),
    .clr_rdy    (clr_rdy),
    .resp       (resp),
    .resp_cmplt (resp_cmplt)
  );

endmodule

// File: tb/tb_comm_master.sv
// Scoreboard bench for comm_master: stimulus pushes expected TX bytes,
// completion latencies and response bytes; monitors pop and compare.
`timescale 1ns/1ps
module tb_comm_master;
  import comm_pkg::*;

  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        clr_rdy = 1'b0;
  logic        loop_en = 1'b0;
  logic        rx_tb = 1'b1;
  logic        TX, RX, cmd_cmplt, resp_cmplt;
  logic [7:0]  resp;

  assign RX = loop_en ? TX : rx_tb;

  always #5 clk = ~clk;

  comm_master #(.BAUD_DIV(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .snd_cmd    (snd_cmd),
    .cmd        (cmd),
    .TX         (TX),
    .RX         (RX),
    .cmd_cmplt  (cmd_cmplt),
    .resp       (resp),
    .resp_cmplt (resp_cmplt),
    .clr_rdy    (clr_rdy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         chained;
  } tx_exp_t;

  tx_exp_t    tx_q[$];
  int         cmplt_q[$];
  logic [7:0] resp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // TX monitor: decodes frames at bit centres
  initial begin
    logic    tx_prev;
    bit      act;
    int      start_c, last_start, rel;
    logic [9:0] bits;
    tx_exp_t e;
    tx_prev = 1'b1; act = 0; start_c = 0; last_start = -100000; bits = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 0;
        tx_prev = 1'b1;
      end else begin
        if (!act) begin
          if (tx_prev && !TX) begin
            act = 1;
            start_c = cyc;
          end
        end else begin
          rel = cyc - start_c;
          if (rel % B == B / 2) begin
            bits[rel / B] = TX;
            if (rel / B == 9) begin
              act = 0;
              if (tx_q.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_unexpected: got byte %0h expected none", bits[8:1]);
              end else begin
                e = tx_q.pop_front();
                check("tx_byte", 32'(bits[8:1]), 32'(e.data));
                check("tx_framing", 32'({bits[9], bits[0]}), 32'h2);
                if (e.chained) check("tx_gap", start_c - last_start, 10 * B);
              end
              last_start = start_c;
            end
          end
        end
        tx_prev = TX;
      end
    end
  end

  // cmd_cmplt monitor: each rise must match one accepted command
  initial begin
    logic cc_prev;
    int   s, lat;
    cc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_cmplt && !cc_prev) begin
        if (cmplt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmplt_unexpected: got rise at cycle %0d expected none", cyc);
        end else begin
          s = cmplt_q.pop_front();
          lat = cyc - s;
          total++;
          if (lat < 20 * B + 1 || lat > 20 * B + 3) begin
            bad++;
            $display("FAIL cmplt_latency: got %0d expected %0d..%0d", lat, 20 * B + 1, 20 * B + 3);
          end else begin
            $display("ok   cmplt_latency: %0d", lat);
          end
        end
      end
      cc_prev = cmd_cmplt;
    end
  end

  // resp monitor: each resp_cmplt rise pops one expected byte
  initial begin
    logic rc_prev;
    rc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && resp_cmplt && !rc_prev) begin
        if (resp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got %0h expected none", resp);
        end else begin
          check("resp_byte", 32'(resp), 32'(resp_q.pop_front()));
        end
      end
      rc_prev = resp_cmplt;
    end
  end

  task automatic send(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    cmd = 16'hDEAD;
    tx_q.push_back('{c[15:8], 1'b0});
    tx_q.push_back('{c[7:0], 1'b1});
    cmplt_q.push_back(cyc);
    check("cmplt_clear_on_accept", 32'(cmd_cmplt), 32'h0);
  endtask

  task automatic wait_cmplt(input string name);
    int n;
    n = 0;
    while (cmd_cmplt !== 1'b1 && n < 30 * B) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cmd_cmplt), 32'h1);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    resp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_tb = f[i];
      repeat (B - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_tb = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset then idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx", 32'(TX), 32'h1);
    check("rst_cmd_cmplt", 32'(cmd_cmplt), 32'h0);
    check("rst_resp_cmplt", 32'(resp_cmplt), 32'h0);
    check("rst_resp", 32'(resp), 32'h0);

    // basic two-byte command 0x4003
    send(make_cmd(CMD_OP_WRITE, 6'h00, 8'h03));
    wait_cmplt("cmd_4003_done");
    repeat (10) @(negedge clk);
    check("cmplt_sticky", 32'(cmd_cmplt), 32'h1);

    // loopback 0x41A5
    loop_en = 1'b1;
    resp_q.push_back(8'h41);
    resp_q.push_back(RESP_ACK);
    send(16'h41A5);
    n = 0;
    while (resp_cmplt !== 1'b1 && n < 14 * B) begin
      @(negedge clk);
      n++;
    end
    check("loop_first_resp", 32'(resp_cmplt), 32'h1);
    pulse_clr();
    check("clr_rdy_clears", 32'(resp_cmplt), 32'h0);
    wait_cmplt("cmd_41a5_done");
    repeat (4) @(negedge clk);
    check("loop_resp_hold", 32'(resp), 32'(RESP_ACK));
    loop_en = 1'b0;
    pulse_clr();

    // re-pulse mid-transmission, with an independent incoming byte
    fork
      send(16'h0102);
      rx_byte(8'h3C);
    join
    repeat (5 * B) @(negedge clk);
    cmd = 16'hFFFF;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    wait_cmplt("cmd_0102_done");
    repeat (25 * B) @(negedge clk);
    check("rx_during_tx", 32'(resp), 32'h3C);

    // RX glitch must not start a frame
    pulse_clr();
    @(negedge clk);
    rx_tb = 1'b0;
    repeat (B / 4) @(negedge clk);
    rx_tb = 1'b1;
    repeat (15 * B) @(negedge clk);
    check("glitch_no_cmplt", 32'(resp_cmplt), 32'h0);
    check("glitch_resp_kept", 32'(resp), 32'h3C);

    // reset in the middle of data bit 4 of the high byte
    send(16'h1234);
    n = 0;
    while (TX !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("midrst_tx_started", 32'(TX), 32'h0);
    repeat (5 * B + B / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(TX), 32'h1);
    check("midrst_cmd_cmplt", 32'(cmd_cmplt), 32'h0);
    check("midrst_resp", 32'(resp), 32'h0);
    tx_q.delete();
    cmplt_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(make_cmd(CMD_OP_READ, 6'h15, 8'h00));
    wait_cmplt("cmd_after_rst_done");

    repeat (4 * B) @(negedge clk);
    check("tx_q_drained", tx_q.size(), 32'h0);
    check("cmplt_q_drained", cmplt_q.size(), 32'h0);
    check("resp_q_drained", resp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comm_master.md
Name: comm_master

Overview:
- Host-side UART command master used by logic-analyzer benches and host models to drive the LA_dig command interface.
- Serializes a 16-bit command as two 8N1 UART bytes, high byte first.
- Deserializes the single 8-bit response byte the device returns.
- Raises completion flags for command sent and response received.

Parameters:
- BAUD_DIV, 109, system clocks per UART bit period (921.6 kbaud at 100 MHz); legal range 4..4095.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- snd_cmd  input  1  one-cycle pulse; start sending cmd.
- cmd  input  16  command word; cmd[15:8] is sent first, then cmd[7:0].
- TX  output  1  UART serial out; idles high.
- RX  input  1  UART serial in; idles high.
- cmd_cmplt  output  1  both command bytes fully transmitted.
- resp  output  8  last received response byte.
- resp_cmplt  output  1  response byte valid (ready flag).
- clr_rdy  input  1  clears resp_cmplt.

Behaviour:
- Reset values: TX=1, cmd_cmplt=0, resp=8'h00, resp_cmplt=0, master FSM in IDLE, transmitter and receiver idle.
- UART frame format: 8N1, LSB first.
  - Start bit = 0, then 8 data bits, then stop bit = 1.
  - Each bit lasts exactly BAUD_DIV clocks, so a frame is 10*BAUD_DIV clocks.
- Master FSM has three states: IDLE, SEND_HI, SEND_LO.
- IDLE:
  - On snd_cmd=1, capture cmd into a 16-bit holding register.
  - Clear cmd_cmplt and start transmitting cmd[15:8].
  - TX start bit appears on the clock after snd_cmd is sampled.
  - Next state: SEND_HI.
- SEND_HI: when the transmitter's stop bit ends, start transmitting the low byte on the next clock with no idle gap. Next state: SEND_LO.
- SEND_LO: when the stop bit ends, set cmd_cmplt=1. Next state: IDLE.
- cmd_cmplt is sticky. It stays high until the next accepted snd_cmd.
- snd_cmd asserted while not in IDLE is ignored. The holding register is not altered.
- Changes on the cmd input after capture have no effect on the bytes sent.
- Command latency from snd_cmd to cmd_cmplt rising is 20*BAUD_DIV + 2 clocks (±1).
- Receiver input path:
  - RX is double-flopped for metastability, with preset-to-1 on reset.
  - A falling edge on the synchronized RX in idle starts a frame.
- Receiver sampling:
  - Sample the start bit at BAUD_DIV/2.
  - If the start bit is high at that sample, abort and return to idle (glitch rejection).
  - Otherwise sample each data bit at its mid-point and shift it in LSB first.
- Receiver completion:
  - At the stop-bit mid-point, load resp and set resp_cmplt=1.
  - No framing-error flag; a bad stop bit still loads resp.
- resp_cmplt clears on clr_rdy=1 or on detection of a new start bit.
- If clr_rdy and frame completion occur in the same cycle, completion wins and resp_cmplt=1.
- resp holds its value until the next completed frame.
- Transmitter and receiver are fully independent. A response can be received during command transmission.
- Reset asserted mid-frame:
  - Immediately forces TX=1 and aborts both paths.
  - Clears both flags and resp.
  - No partial byte completes after reset.

Decomposition:
- Shared package comm_pkg holds:
  - the BAUD_DIV default;
  - the master state enum (IDLE, SEND_HI, SEND_LO);
  - command encoding constants: bits[15:14] 01=write, 00=read; bits[13:8] register address; bits[7:0] data;
  - ACK response constant 8'hA5.
- One sub-module, uart_xcvr, holds:
  - the baud counter, bit counter and shift register for TX;
  - the same for RX, plus the RX synchronizer.
- comm_master holds only the byte-sequencing FSM and the holding register.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 clocks, release → TX=1, cmd_cmplt=0, resp_cmplt=0, resp=8'h00.
- Command 16'h4003, BAUD_DIV=8 → TX shows the 0x40 frame (bits 0,0,0,0,0,0,1,0 LSB-first) then the 0x03 frame back-to-back. cmd_cmplt rises ~162 clocks after snd_cmd.
- Loopback, TX wired to RX, cmd=16'h41A5 → resp_cmplt pulses after the first frame with resp=8'h41, then after the second with resp=8'hA5. clr_rdy between frames clears resp_cmplt.
- snd_cmd re-pulsed with cmd=16'hFFFF mid-transmission of 16'h0102 → TX still sends 0x01, 0x02. cmd_cmplt is set only once.
- RX glitch: drive RX low for BAUD_DIV/4 clocks, then high → no frame received, resp_cmplt stays 0.
- Reset mid-frame: assert rst_n=0 during data bit 4 of the high byte → TX=1 at once, cmd_cmplt=0. A subsequent snd_cmd sends a fresh complete command.
